// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode/writeback handshake bundle between the pipeline and the register scoreboard.
interface reg_scoreboard_if #(parameter int AW = 5);
    logic          id_fire;
    logic          id_RegWr;
    logic [AW-1:0] id_rd;
    logic          id_rs1_en;
    logic          id_rs2_en;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic          wb_fire;
    logic          wb_RegWr;
    logic [AW-1:0] wb_rd;
    logic          flush;
    logic          raw_stall;
    logic          pending_any;
    logic          sb_err;
    modport master (
        output id_fire, id_RegWr, id_rd, id_rs1_en, id_rs2_en, id_rs1, id_rs2,
               wb_fire, wb_RegWr, wb_rd, flush,
        input  raw_stall, pending_any, sb_err
    );
    modport slave (
        input  id_fire, id_RegWr, id_rd, id_rs1_en, id_rs2_en, id_rs1, id_rs2,
               wb_fire, wb_RegWr, wb_rd, flush,
        output raw_stall, pending_any, sb_err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-flight writer counters producing RAW/WAW issue stalls.
module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input logic         clk,
    input logic         rst,
    reg_scoreboard_if.slave sb
);
    localparam int AW = $clog2(NREG);
    localparam logic [CNT_W-1:0] MAX = '1;
    logic             w_iss, w_ret, w_same, w_ovf, w_unf;
    logic [CNT_W-1:0] w_cnt [NREG];
    logic [CNT_W-1:0] w_eff [NREG];
    logic [NREG-1:0]  w_nz;
    logic             r_err;
    assign w_iss  = sb.id_fire && sb.id_RegWr && sb.id_rd != '0;
    assign w_ret  = sb.wb_fire && sb.wb_RegWr && sb.wb_rd != '0;
    assign w_same = w_iss && w_ret && sb.id_rd == sb.wb_rd;
    assign w_ovf  = w_iss && !w_same && w_cnt[sb.id_rd] == MAX;
    assign w_unf  = w_ret && !w_same && w_cnt[sb.wb_rd] == '0;
    for (genvar g = 0; g < NREG; g++) begin : g_reg
        if (g == 0) begin : g_x0
            assign w_cnt[g] = '0;
            assign w_eff[g] = '0;
            assign w_nz[g]  = 1'b0;
        end else begin : g_rn
            logic             w_inc, w_dec;
            logic [CNT_W-1:0] r_cnt;
            assign w_inc = w_iss && sb.id_rd == AW'(g);
            assign w_dec = w_ret && sb.wb_rd == AW'(g);
            always_ff @(posedge clk or posedge rst)
                if (rst) r_cnt <= '0;
                else if (sb.flush) r_cnt <= '0;
                else if (w_inc && !w_dec && r_cnt != MAX) r_cnt <= r_cnt + 1'b1;
                else if (w_dec && !w_inc && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            assign w_cnt[g] = r_cnt;
            // write-first regfile: a retiring writer is already visible to decode
            assign w_eff[g] = (w_dec && r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
            assign w_nz[g]  = |r_cnt;
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) r_err <= 1'b0;
        else if (!sb.flush && (w_ovf || w_unf)) r_err <= 1'b1;
    assign sb.raw_stall = (sb.id_rs1_en && sb.id_rs1 != '0 && w_eff[sb.id_rs1] != '0)
                       || (sb.id_rs2_en && sb.id_rs2 != '0 && w_eff[sb.id_rs2] != '0)
                       || (sb.id_RegWr && sb.id_rd != '0 && w_eff[sb.id_rd] == MAX);
    assign sb.pending_any = |w_nz;
    assign sb.sb_err      = r_err;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed vectors with hand-computed expectations for reg_scoreboard.
module tb_reg_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    reg_scoreboard_if bus ();
    reg_scoreboard #(.NREG(32), .CNT_W(2)) dut (.clk(clk), .rst(rst), .sb(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic idle();
        bus.id_fire = 0; bus.id_RegWr = 0; bus.id_rd = 0;
        bus.id_rs1_en = 0; bus.id_rs2_en = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
        bus.wb_fire = 0; bus.wb_RegWr = 0; bus.wb_rd = 0; bus.flush = 0;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic iss(input logic [4:0] rd);
        bus.id_fire = 1; bus.id_RegWr = 1; bus.id_rd = rd;
    endtask
    task automatic ret(input logic [4:0] rd);
        bus.wb_fire = 1; bus.wb_RegWr = 1; bus.wb_rd = rd;
    endtask
    task automatic rs1(input logic [4:0] r);
        bus.id_rs1_en = 1; bus.id_rs1 = r; #1;
    endtask
    task automatic sync_reset();
        idle(); rst = 1; tick(); rst = 0; #1;
    endtask
    initial begin
        idle();
        #1;
        chk("rst_pending", bus.pending_any, 0);
        chk("rst_err", bus.sb_err, 0);
        chk("rst_stall", bus.raw_stall, 0);
        tick(); tick();
        rst = 0; #1;
        // issue x5, then RAW on rs1=5, resolved by same-cycle retire
        iss(5); tick(); idle();
        rs1(5);
        chk("x5_stall", bus.raw_stall, 1);
        chk("x5_pending", bus.pending_any, 1);
        ret(5); #1;
        chk("x5_bypass", bus.raw_stall, 0);
        tick(); idle(); rs1(5);
        chk("x5_clear", bus.raw_stall, 0);
        chk("x5_pend0", bus.pending_any, 0);
        // three writers to x7 saturate, fourth overflows
        idle();
        iss(7); tick(); tick(); tick(); idle();
        bus.id_RegWr = 1; bus.id_rd = 7; #1;
        chk("x7_waw_max", bus.raw_stall, 1);
        chk("x7_err0", bus.sb_err, 0);
        iss(7); tick(); idle();
        chk("x7_ovf_err", bus.sb_err, 1);
        bus.id_RegWr = 1; bus.id_rd = 7; #1;
        chk("x7_still_max", bus.raw_stall, 1);
        idle(); ret(7); tick(); tick(); idle(); rs1(7);
        chk("x7_one_left", bus.raw_stall, 1);
        ret(7); tick(); idle(); rs1(7);
        chk("x7_drained", bus.raw_stall, 0);
        chk("x7_pend0", bus.pending_any, 0);
        // same-rd issue+retire holds; different rds update both
        sync_reset();
        chk("rst2_err", bus.sb_err, 0);
        iss(9); tick(); idle();
        iss(9); ret(9); tick(); idle(); rs1(9);
        chk("x9_held", bus.raw_stall, 1);
        idle(); iss(3); ret(9); tick(); idle(); rs1(3);
        chk("x3_inc", bus.raw_stall, 1);
        rs1(9);
        chk("x9_dec", bus.raw_stall, 0);
        chk("x9_no_unf", bus.sb_err, 0);
        idle(); ret(3); tick(); idle();
        // x0 is never tracked
        iss(0); tick(); idle(); rs1(0);
        chk("x0_stall", bus.raw_stall, 0);
        chk("x0_pending", bus.pending_any, 0);
        idle(); bus.id_RegWr = 1; bus.id_rd = 0; #1;
        chk("x0_waw", bus.raw_stall, 0);
        idle(); ret(0); tick(); idle();
        chk("x0_ret_err", bus.sb_err, 0);
        // flush clears everything and ignores same-cycle issue
        iss(4); tick(); tick(); idle(); iss(8); tick(); idle();
        chk("fl_pend1", bus.pending_any, 1);
        iss(4); bus.flush = 1; rs1(4);
        chk("fl_stall_indep", bus.raw_stall, 1);
        tick(); idle(); rs1(4);
        chk("fl_x4_clear", bus.raw_stall, 0);
        chk("fl_pend0", bus.pending_any, 0);
        chk("fl_err0", bus.sb_err, 0);
        idle(); ret(8); tick(); idle();
        chk("fl_unf_err", bus.sb_err, 1);
        bus.flush = 1; tick(); idle();
        chk("fl_err_kept", bus.sb_err, 1);
        // asynchronous reset between edges
        iss(12); tick(); tick(); idle();
        chk("ar_pend1", bus.pending_any, 1);
        #2 rst = 1; #1;
        chk("ar_pend0", bus.pending_any, 0);
        chk("ar_err0", bus.sb_err, 0);
        #1 rst = 0;
        tick(); rs1(12);
        chk("ar_x12", bus.raw_stall, 0);
        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter NREG, 32, number of architectural integer registers tracked.
REQ-002 Parameter CNT_W, 2, width of each per-register pending counter (max 3 in-flight writers).
REQ-003 clk  input  1  Single clock; all state updates on the rising edge.
REQ-004 rst  input  1  Asynchronous, active-high reset.
REQ-005 id_fire  input  1  Decode-to-execute handshake completes this cycle (valid && allow_in).
REQ-006 id_RegWr  input  1  Issuing instruction writes the register file.
REQ-007 id_rd  input  5  Issuing instruction's destination register.
REQ-008 id_rs1_en, id_rs2_en  input  1 each  Decode-stage instruction reads rs1/rs2.
REQ-009 id_rs1, id_rs2  input  5 each  Decode-stage source registers.
REQ-010 wb_fire  input  1  Writeback-stage instruction retires this cycle (wb_valid && wb_ready).
REQ-011 wb_RegWr  input  1  Retiring instruction writes the register file.
REQ-012 wb_rd  input  5  Retiring instruction's destination register.
REQ-013 flush  input  1  Pipeline kill from trap/ecall/mret/interrupt redirect.
REQ-014 raw_stall  output  1  Decode instruction must not issue (combinational).
REQ-015 pending_any  output  1  At least one counter is non-zero (registered-state view).
REQ-016 sb_err  output  1  Sticky overflow/underflow error flag.

Function
REQ-017 The block SHALL hold one CNT_W-bit counter per register, indices 1..NREG-1; register x0 SHALL never be tracked, and its counter SHALL read 0 at all times.
REQ-018 Issue event: id_fire && id_RegWr && id_rd!=0 SHALL increment cnt[id_rd] at the clock edge.
REQ-019 Retire event: wb_fire && wb_RegWr && wb_rd!=0 SHALL decrement cnt[wb_rd] at the clock edge.
REQ-020 Issue and retire to the same rd in the same cycle SHALL leave that counter unchanged; issue and retire to different rds SHALL update both counters.
REQ-021 Effective count eff[r] = cnt[r] - 1 when a retire event targets r this cycle, otherwise cnt[r] (write-first regfile: WB data is visible to decode in the same cycle).
REQ-022 raw_stall SHALL be 1 iff (id_rs1_en && id_rs1!=0 && eff[id_rs1]!=0) || (id_rs2_en && id_rs2!=0 && eff[id_rs2]!=0) || (id_RegWr && id_rd!=0 && eff[id_rd]==max), where max = 2^CNT_W-1.
REQ-023 raw_stall SHALL NOT depend on id_fire or on flush (no combinational loop through the handshake).
REQ-024 Overflow: issue event to a counter already at max with no same-cycle retire SHALL keep the counter at max and set sb_err.
REQ-025 Underflow: retire event to a counter at 0 with no same-cycle issue SHALL keep the counter at 0 and set sb_err.
REQ-026 flush=1 SHALL clear every counter to 0 at the clock edge; issue and retire events in that cycle SHALL be ignored, and sb_err SHALL be unaffected.
REQ-027 pending_any SHALL be the OR of all registered counters (it does not reflect same-cycle retire).
REQ-028 sb_err SHALL remain set once set, until reset.
REQ-029 Latency: an issue becomes visible on raw_stall one cycle after the edge at which id_fire was sampled; a retire becomes visible in the same cycle via REQ-021.

Reset
REQ-030 While rst=1, all counters SHALL be 0 and sb_err SHALL be 0, asynchronously, regardless of clk.
REQ-031 The outputs SHALL reset to pending_any=0 and sb_err=0; raw_stall SHALL then be 0 except for the max term, which cannot assert with all counters at 0.
REQ-032 Reset asserted mid-operation SHALL discard all pending state; the first edge after deassertion SHALL apply normal issue/retire rules from the all-zero state.

Verification
REQ-033 Issue x5 (id_fire=1, id_RegWr=1, id_rd=5); next cycle id_rs1_en=1, id_rs1=5 -> raw_stall=1, pending_any=1; retire wb_rd=5 in the same cycle -> raw_stall=0 that cycle, cnt[5]=0 after the edge.
REQ-034 Issue x7 three times back-to-back -> cnt[7]=3, then decode id_rd=7 with id_RegWr=1 -> raw_stall=1; forcing a fourth id_fire -> cnt[7] stays 3 and sb_err=1.
REQ-035 cnt[9]=1; same cycle issue rd=9 and retire rd=9 -> cnt[9] stays 1; same cycle issue rd=3 and retire rd=9 -> cnt[3]=1, cnt[9]=0.
REQ-036 Issue to rd=0, then read rs1=0 -> raw_stall=0, pending_any=0; retire rd=0 with all counters 0 -> sb_err=0.
REQ-037 cnt[4]=2 and cnt[8]=1; flush=1 with simultaneous issue rd=4 -> all counters 0 and pending_any=0 next cycle; retire rd=8 after that -> sb_err=1.
REQ-038 Assert rst asynchronously between edges with cnt[12]=2 and sb_err=1 -> pending_any=0 and sb_err=0 immediately, and no stall on rs1=12 after deassertion.
